secure_xfer_ctrl: RTL and testbench

Parametrised, key-gated block-transfer engine between the data memory and the register file.
- Accepts one burst request per handshake and checks the request key against the access keys published by memory and registers.
- Moves LEN words one at a time in the requested direction, then reports done or error.
- Sits between the memory and registers blocks, replacing the ad-hoc combinational security path with a sequenced, checked datapath.

---
 rtl/secure_xfer_pkg.sv | 24 ++
 rtl/secure_key_check.sv | 38 +++
 rtl/secure_xfer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_secure_xfer_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_xfer_pkg.sv
// secure_xfer_pkg
// Shared definitions for the key-gated block-transfer engine: FSM state
// encoding, transfer direction constants and default datapath widths.
// Optional build macro used by the engine: SECURE_XFER_SCRAMBLE_EN.
package secure_xfer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 8;
  localparam int KEY_W_DEF  = 16;

  localparam logic DIR_MEM2REG = 1'b0;
  localparam logic DIR_REG2MEM = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } xfer_state_e;

endpackage

// File: rtl/secure_key_check.sv
// secure_key_check
// Combinational admission test for a captured burst request.
// Ports:
//   req_key_i, key_mem_i, key_reg_i : requester key and the two access keys
//   mem_addr_i, reg_addr_i          : burst start addresses
//   len_i                           : burst length in words
//   pass_o                          : 1 when keys match and both ranges fit
module secure_key_check
  import secure_xfer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int KEY_W  = KEY_W_DEF
) (
  input  logic [KEY_W-1:0]  req_key_i,
  input  logic [KEY_W-1:0]  key_mem_i,
  input  logic [KEY_W-1:0]  key_reg_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              pass_o
);

  // One bit wider than the wider operand so the end address never wraps.
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  logic [SUM_W-1:0] mem_end;
  logic [SUM_W-1:0] reg_end;
  logic [SUM_W-1:0] limit;
  logic             key_ok;

  assign limit   = SUM_W'(1) << ADDR_W;
  assign mem_end = SUM_W'(mem_addr_i) + SUM_W'(len_i);
  assign reg_end = SUM_W'(reg_addr_i) + SUM_W'(len_i);
  assign key_ok  = (req_key_i == key_mem_i) && (req_key_i == key_reg_i);
  assign pass_o  = key_ok && (mem_end <= limit) && (reg_end <= limit);

endmodule

// File: rtl/secure_xfer_ctrl.sv
// secure_xfer_ctrl
// Key-gated block-transfer engine between data memory and register file.
// A request is captured on req_valid && req_ready, checked for one cycle,
// then moved one word per READ/WRITE pair; done or err pulses at the end.
// Ports:
//   req_*                      : burst request handshake and fields
//   key_mem, key_reg           : access keys, sampled only in CHECK
//   mem_rd_*, mem_wr_*         : data memory read (1-cycle latency) / write
//   reg_rd_*, reg_wr_*         : register file read (1-cycle latency) / write
//   busy, done, err, xfer_cnt  : status
// Build option: SECURE_XFER_SCRAMBLE_EN XORs moved data with the
// requester key replicated across the word.
module secure_xfer_ctrl
  import secure_xfer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int KEY_W  = KEY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [ADDR_W-1:0] req_mem_addr,
  input  logic [ADDR_W-1:0] req_reg_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [KEY_W-1:0]  key_mem,
  input  logic [KEY_W-1:0]  key_reg,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  xfer_cnt
);

  xfer_state_e       state_q, state_d;
  logic              dir_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [LEN_W-1:0]  len_q;
  logic [KEY_W-1:0]  key_q;
  logic [LEN_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic              accept;
  logic              pass;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] xfer_data;

  assign accept = req_valid && (state_q == IDLE);

  secure_key_check #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .KEY_W  (KEY_W)
  ) u_key_check (
    .req_key_i  (key_q),
    .key_mem_i  (key_mem),
    .key_reg_i  (key_reg),
    .mem_addr_i (mem_addr_q),
    .reg_addr_i (reg_addr_q),
    .len_i      (len_q),
    .pass_o     (pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_MEM2REG;
      mem_addr_q <= '0;
      reg_addr_q <= '0;
      len_q      <= '0;
      key_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      reg_addr_q <= reg_addr_d;
      xfer_cnt_q <= xfer_cnt_d;
      if (accept) begin
        dir_q <= req_dir;
        len_q <= req_len;
        key_q <= req_key;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    reg_addr_d = reg_addr_q;
    xfer_cnt_d = xfer_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CHECK;
          mem_addr_d = req_mem_addr;
          reg_addr_d = req_reg_addr;
          xfer_cnt_d = '0;
        end
      end
      CHECK: begin
        if (!pass)              state_d = ERR;
        else if (len_q == '0)   state_d = DONE;
        else                    state_d = READ;
      end
      READ: state_d = WRITE;
      WRITE: begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        reg_addr_d = reg_addr_q + ADDR_W'(1);
        xfer_cnt_d = xfer_cnt_q + LEN_W'(1);
        state_d    = (xfer_cnt_d == len_q) ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives in the WRITE cycle and is forwarded combinationally.
  assign src_data = (dir_q == DIR_REG2MEM) ? reg_rd_data : mem_rd_data;

`ifdef SECURE_XFER_SCRAMBLE_EN
  logic [DATA_W-1:0] mask;
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign mask[gi] = key_q[gi % KEY_W];
  end
  assign xfer_data = src_data ^ mask;
`else
  assign xfer_data = src_data;
`endif

  // Strobes decode straight from the state register so the asynchronous
  // reset removes them immediately.
  assign mem_rd_en = (state_q == READ)  && (dir_q == DIR_MEM2REG);
  assign reg_rd_en = (state_q == READ)  && (dir_q == DIR_REG2MEM);
  assign mem_wr_en = (state_q == WRITE) && (dir_q == DIR_REG2MEM);
  assign reg_wr_en = (state_q == WRITE) && (dir_q == DIR_MEM2REG);

  assign mem_rd_addr = mem_rd_en ? mem_addr_q : '0;
  assign reg_rd_addr = reg_rd_en ? reg_addr_q : '0;
  assign mem_wr_addr = mem_wr_en ? mem_addr_q : '0;
  assign reg_wr_addr = reg_wr_en ? reg_addr_q : '0;
  assign mem_wr_data = mem_wr_en ? xfer_data  : '0;
  assign reg_wr_data = reg_wr_en ? xfer_data  : '0;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_secure_xfer_ctrl.sv
module tb_secure_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_dir;
  logic [9:0]  req_mem_addr, req_reg_addr;
  logic [7:0]  req_len;
  logic [15:0] req_key, key_mem, key_reg;
  logic        mem_rd_en, mem_wr_en, reg_rd_en, reg_wr_en;
  logic [9:0]  mem_rd_addr, mem_wr_addr, reg_rd_addr, reg_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data, reg_rd_data, reg_wr_data;
  logic        busy, done, err;
  logic [7:0]  xfer_cnt;

  secure_xfer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_mem_addr(req_mem_addr), .req_reg_addr(req_reg_addr),
    .req_len(req_len), .req_key(req_key),
    .key_mem(key_mem), .key_reg(key_reg),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .done(done), .err(err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Environment: memory and register file with one-cycle registered reads.
  logic [31:0] mem_arr [1024];
  logic [31:0] reg_arr [1024];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_arr[mem_rd_addr];
    if (reg_rd_en) reg_rd_data <= reg_arr[reg_rd_addr];
    if (mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
    if (reg_wr_en) reg_arr[reg_wr_addr] <= reg_wr_data;
  end

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;

  typedef struct {
    logic        is_mem;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_exp_t;
  wr_exp_t sb[$];

  typedef struct {
    logic        dir;
    logic [9:0]  mem_addr;
    logic [9:0]  reg_addr;
    logic [7:0]  len;
    logic [15:0] rkey;
    logic [15:0] kmem;
    logic [15:0] kreg;
    logic        exp_err;
    int          exp_cyc;
    logic [7:0]  exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_mask(input logic [15:0] k);
    logic [31:0] m;
    m = '0;
`ifdef SECURE_XFER_SCRAMBLE_EN
    for (int i = 0; i < 32; i++) m[i] = k[i % 16];
`endif
    return m;
  endfunction

  // Write monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (rst_n && (mem_rd_en || reg_rd_en || mem_wr_en || reg_wr_en)) begin
      strobe_cnt += int'(mem_rd_en) + int'(reg_rd_en) + int'(mem_wr_en) + int'(reg_wr_en);
      chk("one_strobe", 64'(int'(mem_rd_en) + int'(reg_rd_en) + int'(mem_wr_en) + int'(reg_wr_en)), 64'd1);
      if (mem_wr_en || reg_wr_en) begin
        wr_exp_t e;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got mem=%0b reg=%0b expected none", mem_wr_en, reg_wr_en);
        end else begin
          e = sb.pop_front();
          chk("wr_target", {63'd0, mem_wr_en}, {63'd0, e.is_mem});
          chk("wr_addr", mem_wr_en ? mem_wr_addr : reg_wr_addr, e.addr);
          chk("wr_data", mem_wr_en ? mem_wr_data : reg_wr_data, e.data);
        end
      end
    end
  end

  task automatic drive_req(input vec_t v);
    req_dir      = v.dir;
    req_mem_addr = v.mem_addr;
    req_reg_addr = v.reg_addr;
    req_len      = v.len;
    req_key      = v.rkey;
    key_mem      = v.kmem;
    key_reg      = v.kreg;
    req_valid    = 1'b1;
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.len); i++) begin
        wr_exp_t e;
        logic [9:0] ma, ra;
        ma = v.mem_addr + 10'(i);
        ra = v.reg_addr + 10'(i);
        e.is_mem = v.dir;
        e.addr   = v.dir ? ma : ra;
        e.data   = (v.dir ? reg_arr[ra] : mem_arr[ma]) ^ tb_mask(v.rkey);
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_req(input vec_t v);
    int c;
    bit fin;
    @(negedge clk);
    chk("ready_before", {63'd0, req_ready}, 64'd1);
    strobe_cnt = 0;
    drive_req(v);
    @(posedge clk);
    #1;
    // Scramble request fields after capture; the engine must not look at them.
    req_valid    = 1'b0;
    req_key      = 16'($urandom);
    req_mem_addr = 10'($urandom);
    req_reg_addr = 10'($urandom);
    req_len      = 8'($urandom);
    req_dir      = ~v.dir;
    c = 0;
    fin = 0;
    while (!fin && c < 600) begin
      @(negedge clk);
      c++;
      if (c == 2 && !v.exp_err) begin
        key_mem = ~key_mem;
        key_reg = ~key_reg;
      end
      if (done || err) fin = 1;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no done/err after %0d cycles expected cycle %0d", c, v.exp_cyc);
    end else begin
      chk("outcome_err", {63'd0, err}, {63'd0, v.exp_err});
      chk("end_cycle", 64'(c), 64'(v.exp_cyc));
      chk("xfer_cnt", {56'd0, xfer_cnt}, {56'd0, v.exp_cnt});
    end
    @(negedge clk);
    chk("ready_after", {61'd0, req_ready, busy, done | err}, 64'd4);
    chk("strobe_total", 64'(strobe_cnt), v.exp_err ? 64'd0 : 64'(2 * int'(v.len)));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    $display("xfer dir=%0d mem=0x%03h reg=0x%03h len=%0d -> %s cycle=%0d cnt=%0d",
             v.dir, v.mem_addr, v.reg_addr, v.len, err ? "err" : (done ? "done" : "none"), c, xfer_cnt);
  endtask

  vec_t vecs [9];

  initial begin
    vec_t v;
    int c;
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = 32'hC0DE_0000 | 32'(i);
      reg_arr[i] = 32'h5EED_0000 | 32'(i);
    end
    reg_arr[10'h050] = 32'h1234_5678;

    //            dir  mem     reg     len    rkey      kmem      kreg     err cyc cnt
    vecs[0] = '{1'b0, 10'h010, 10'h005, 8'd4, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0, 10, 8'd4};
    vecs[1] = '{1'b1, 10'h020, 10'h020, 8'd3, 16'h1234, 16'h1234, 16'h9999, 1'b1, 2,  8'd0};
    vecs[2] = '{1'b0, 10'h3FE, 10'h100, 8'd2, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0, 6,  8'd2};
    vecs[3] = '{1'b0, 10'h3FE, 10'h100, 8'd3, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 2,  8'd0};
    vecs[4] = '{1'b1, 10'h200, 10'h3FF, 8'd1, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b0, 4,  8'd1};
    vecs[5] = '{1'b1, 10'h200, 10'h3FF, 8'd2, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b1, 2,  8'd0};
    vecs[6] = '{1'b0, 10'h030, 10'h030, 8'd0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0, 2,  8'd0};
    vecs[7] = '{1'b1, 10'h300, 10'h040, 8'd7, 16'h7777, 16'h7776, 16'h7777, 1'b1, 2,  8'd0};
    vecs[8] = '{1'b1, 10'h300, 10'h040, 8'd7, 16'h7777, 16'h7777, 16'h7777, 1'b0, 16, 8'd7};

    rst_n = 1'b0;
    req_valid = 1'b0; req_dir = 1'b0; req_mem_addr = '0; req_reg_addr = '0;
    req_len = '0; req_key = '0; key_mem = '0; key_reg = '0;
    #1;
    chk("reset_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_outs", {busy, done, err, mem_rd_en, mem_wr_en, reg_rd_en, reg_wr_en, xfer_cnt,
                       mem_rd_addr, mem_wr_addr, reg_rd_addr, reg_wr_addr}, 64'd0);
    chk("reset_data", {mem_wr_data, reg_wr_data}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_req(vecs[i]);

    // Reset asserted during WRITE of word 2 of a 5-word burst.
    v = '{1'b0, 10'h080, 10'h080, 8'd5, 16'h3C3C, 16'h3C3C, 16'h3C3C, 1'b0, 12, 8'd5};
    @(negedge clk);
    strobe_cnt = 0;
    drive_req(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    c = 0;
    while (c < 5) begin
      @(negedge clk);
      c++;
    end
    chk("mid_write_word2", {62'd0, reg_wr_en, xfer_cnt == 8'd1}, 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_strobes", {60'd0, mem_rd_en, mem_wr_en, reg_rd_en, reg_wr_en}, 64'd0);
    chk("rst_status", {61'd0, busy, done, err}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_quiet", {61'd0, done, err, busy}, 64'd0);
    end
    rst_n = 1'b1;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {61'd0, done, err, busy}, 64'd0);
    end
    chk("partial_kept", reg_arr[10'h080], mem_arr[10'h080] ^ tb_mask(16'h3C3C));
    chk("unwritten_word", reg_arr[10'h081], 32'h5EED_0081);
    $display("xfer reset mid-burst after %0d cycles, strobes=%0d", c, strobe_cnt);
    v = '{1'b0, 10'h090, 10'h090, 8'd3, 16'h3C3C, 16'h3C3C, 16'h3C3C, 1'b0, 8, 8'd3};
    run_req(v);

    // Data path round trip through memory (scrambled when the option is built).
    v = '{1'b1, 10'h060, 10'h050, 8'd1, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 4, 8'd1};
    run_req(v);
    chk("scramble_store", mem_arr[10'h060], 32'h1234_5678 ^ tb_mask(16'h00FF));
    v = '{1'b0, 10'h060, 10'h051, 8'd1, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 4, 8'd1};
    run_req(v);
    chk("scramble_restore", reg_arr[10'h051], 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
